// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and helpers for the keypad entry block
//
// Contents:
//   N_ROWS, N_COLS, N_DIGITS  keypad geometry and entry-buffer depth
//   CNT_W                     width of the debounce/release counter (covers 2..15)
//   kp_state_e                scanner FSM states
//   is_one_hot()              true when exactly one column bit is set
//   col_index()               binary index of a one-hot column vector
//   one_hot4()                2-bit index to 4-bit one-hot vector

package keypad_pkg;

  localparam int N_ROWS   = 4;
  localparam int N_COLS   = 4;
  localparam int N_DIGITS = 6;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_e;

  // Two or more bits set is a ghosting/multi-press pattern, not a key.
  function automatic logic is_one_hot(input logic [N_COLS-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  function automatic logic [1:0] col_index(input logic [N_COLS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_COLS; i++) begin
      if (v[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  function automatic logic [3:0] one_hot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
//
// Ports:
//   clk  in          destination clock
//   rst  in          asynchronous active-high reset, clears both stages
//   d    in  [W-1:0] asynchronous input
//   q    out [W-1:0] synchronized output, two clk edges of latency

module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x4 keypad scanner with debounce and six-digit hex entry buffer
//
// Ports:
//   clk        in         system clock, rising edge
//   rst        in         asynchronous active-high reset
//   scan_tick  in         one-clk strobe; the only time the FSM and counters move
//   cols       in  [3:0]  column sense, active-high, asynchronous
//   clear      in         one-clk pulse, empties data/enables
//   rows       out [3:0]  one-hot row drive
//   key_valid  out        one-clk pulse per accepted key
//   key_code   out [3:0]  last accepted key, {row, col}
//   data       out [23:0] entry buffer, newest digit in [3:0]
//   enables    out [5:0]  per-digit valid mask feeding the display mux

module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_tick,
  input  logic [N_COLS-1:0]     cols,
  input  logic                  clear,
  output logic [N_ROWS-1:0]     rows,
  output logic                  key_valid,
  output logic [3:0]            key_code,
  output logic [4*N_DIGITS-1:0] data,
  output logic [N_DIGITS-1:0]   enables
);

  // The SCAN sample that finds the key already counts as the first match,
  // so DEBOUNCE accepts once cnt has reached DEBOUNCE_TICKS-2.
  localparam logic [CNT_W-1:0] ACCEPT_CNT  = CNT_W'(DEBOUNCE_TICKS - 2);
  localparam logic [CNT_W-1:0] RELEASE_CNT = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [N_COLS-1:0] cols_s;

  kp_state_e         state, state_next;
  logic [1:0]        row_idx, row_idx_next;
  logic [1:0]        col_idx, col_idx_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              accept;
  logic [3:0]        new_code;

  sync_2ff #(
    .WIDTH(N_COLS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cols),
    .q   (cols_s)
  );

  assign rows     = one_hot4(row_idx);
  assign new_code = {row_idx, col_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      col_idx <= 2'd0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      row_idx <= row_idx_next;
      col_idx <= col_idx_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    row_idx_next = row_idx;
    col_idx_next = col_idx;
    cnt_next     = cnt;
    accept       = 1'b0;

    if (scan_tick) begin
      case (state)
        SCAN: begin
          if (is_one_hot(cols_s)) begin
            col_idx_next = col_index(cols_s);
            cnt_next     = '0;
            state_next   = DEBOUNCE;
          end else begin
            row_idx_next = row_idx + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (cols_s == one_hot4(col_idx)) begin
            if (cnt == ACCEPT_CNT) begin
              accept     = 1'b1;
              cnt_next   = '0;
              state_next = HELD;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end else begin
            cnt_next     = '0;
            row_idx_next = row_idx + 2'd1;
            state_next   = SCAN;
          end
        end

        HELD: begin
          // Any column activity restarts the release count, so bounce on
          // release cannot produce a second key.
          if (cols_s == '0) begin
            if (cnt == RELEASE_CNT) begin
              cnt_next     = '0;
              row_idx_next = row_idx + 2'd1;
              state_next   = SCAN;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end else begin
            cnt_next = '0;
          end
        end

        default: begin
          cnt_next   = '0;
          state_next = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= new_code;
    end
  end

  // clear takes priority over a coincident acceptance; the key still
  // shows up on key_valid/key_code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      enables <= '0;
    end else if (clear) begin
      data    <= '0;
      enables <= '0;
    end else if (accept) begin
      data    <= {data[4*N_DIGITS-5:0], new_code};
      enables <= {enables[N_DIGITS-2:0], 1'b1};
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard testbench for keypad_entry

module tb_keypad_entry;

  typedef struct packed {
    logic [3:0]  code;
    logic [23:0] data;
    logic [5:0]  en;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_tick;
  logic [3:0]  cols;
  logic        clear;
  logic [3:0]  rows;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] data;
  logic [5:0]  enables;

  logic        tick_en;
  logic        clear_manual;
  logic        clear_at_tick;
  logic        pressed;
  logic [1:0]  krow;
  logic [1:0]  kcol;
  logic        force_en;
  logic [3:0]  force_val;

  logic [23:0] m_data;
  logic [5:0]  m_en;
  exp_t        exp_q[$];

  int compared   = 0;
  int mismatched = 0;
  int kv_count   = 0;
  int kv_before  = 0;

  keypad_entry #(
    .DEBOUNCE_TICKS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_tick (scan_tick),
    .cols      (cols),
    .clear     (clear),
    .rows      (rows),
    .key_valid (key_valid),
    .key_code  (key_code),
    .data      (data),
    .enables   (enables)
  );

  always #5 clk = ~clk;

  assign clear = clear_manual | (scan_tick & clear_at_tick);

  // Keypad model: a pressed key closes its column only while its row is driven.
  always_comb begin
    cols = 4'b0000;
    if (force_en) cols = force_val;
    else if (pressed && rows[krow]) cols = 4'b0001 << kcol;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scan_tick: one clk high every 8 clks, changed on falling edges.
  initial begin
    scan_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
        repeat (6) @(negedge clk);
      end
    end
  end

  // Monitor: every key_valid pulse must match the oldest expected key.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && key_valid) begin
      kv_count++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_key_valid: got key_code 0x%0h expected no pulse", key_code);
      end else begin
        e = exp_q.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, e.code});
        check("kv_data", {8'd0, data}, {8'd0, e.data});
        check("kv_enables", {26'd0, enables}, {26'd0, e.en});
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (scan_tick) k++;
    end
    #1;
  endtask

  task automatic wait_row(input logic [3:0] r, input string name);
    int k;
    k = 0;
    while (rows !== r && k < 8) begin
      wait_ticks(1);
      k++;
    end
    check(name, {28'd0, rows}, {28'd0, r});
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_manual = 1'b1;
    @(negedge clk);
    clear_manual = 1'b0;
    m_data = 24'd0;
    m_en   = 6'd0;
    check("clear_data", {8'd0, data}, 32'd0);
    check("clear_enables", {26'd0, enables}, 32'd0);
  endtask

  task automatic press_key(input logic [3:0] code, input int hold, input int rel);
    m_data = {m_data[19:0], code};
    m_en   = {m_en[4:0], 1'b1};
    exp_q.push_back({code, m_data, m_en});
    krow    = code[3:2];
    kcol    = code[1:0];
    pressed = 1'b1;
    wait_ticks(hold);
    check($sformatf("accepted_%0h", code), exp_q.size(), 32'd0);
    pressed = 1'b0;
    wait_ticks(rel);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    tick_en       = 1'b0;
    clear_manual  = 1'b0;
    clear_at_tick = 1'b0;
    pressed       = 1'b0;
    krow          = 2'd0;
    kcol          = 2'd0;
    force_en      = 1'b0;
    force_val     = 4'd0;
    m_data        = 24'd0;
    m_en          = 6'd0;

    repeat (3) @(negedge clk);
    check("rst_rows", {28'd0, rows}, 32'h1);
    check("rst_data", {8'd0, data}, 32'd0);
    check("rst_enables", {26'd0, enables}, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    rst     = 1'b0;
    tick_en = 1'b1;

    // Single key 0x9 (row2, col1)
    press_key(4'h9, 12, 6);
    check("k9_data", {8'd0, data}, 32'h000009);
    check("k9_enables", {26'd0, enables}, 32'h01);

    // Short bounce on row0: no key, row advances on the mismatch tick
    wait_row(4'b0001, "bounce_find_row0");
    force_en  = 1'b1;
    force_val = 4'b0001;
    wait_ticks(1);
    check("bounce_row_hold1", {28'd0, rows}, 32'h1);
    wait_ticks(1);
    check("bounce_row_hold2", {28'd0, rows}, 32'h1);
    force_val = 4'b0000;
    wait_ticks(1);
    check("bounce_row_adv", {28'd0, rows}, 32'h2);
    force_en = 1'b0;
    wait_ticks(2);

    // Seven keys: oldest digit drops out, mask saturates
    do_clear();
    kv_before = kv_count;
    for (int k = 1; k <= 7; k++) press_key(4'(k), 12, 6);
    check("seq_data", {8'd0, data}, 32'h234567);
    check("seq_enables", {26'd0, enables}, 32'h3f);
    check("seq_pulses", kv_count - kv_before, 32'd7);

    // Long hold gives one key; 4-tick release then re-press gives another
    kv_before = kv_count;
    press_key(4'h5, 20, 4);
    press_key(4'h5, 12, 6);
    check("hold_pulses", kv_count - kv_before, 32'd2);
    check("hold_data", {8'd0, data}, 32'h456755);
    force_en  = 1'b1;
    force_val = 4'b0011;
    wait_ticks(10);
    force_en = 1'b0;
    wait_ticks(2);
    check("multi_col_pulses", kv_count - kv_before, 32'd2);

    // clear on the accepting edge of key 0xA
    do_clear();
    press_key(4'h1, 12, 6);
    press_key(4'h2, 12, 6);
    check("pre_clear_data", {8'd0, data}, 32'h000012);
    check("pre_clear_enables", {26'd0, enables}, 32'h03);
    wait_row(4'b0100, "clr_find_row2");
    krow    = 2'd2;
    kcol    = 2'd2;
    pressed = 1'b1;
    exp_q.push_back({4'hA, 24'h000000, 6'b000000});
    wait_ticks(3);
    clear_at_tick = 1'b1;
    wait_ticks(1);
    clear_at_tick = 1'b0;
    wait_ticks(2);
    check("clr_accept_seen", exp_q.size(), 32'd0);
    check("clr_key_code", {28'd0, key_code}, 32'hA);
    pressed = 1'b0;
    wait_ticks(6);
    m_data = 24'd0;
    m_en   = 6'd0;

    // Reset mid-debounce abandons the key
    wait_row(4'b0001, "rst_find_row0");
    krow    = 2'd0;
    kcol    = 2'd0;
    pressed = 1'b1;
    wait_ticks(2);
    pressed = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_rows", {28'd0, rows}, 32'h1);
    check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
    rst       = 1'b0;
    kv_before = kv_count;
    wait_ticks(8);
    check("midrst_pulses", kv_count - kv_before, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 4: consecutive scan_tick samples needed to accept a press or a release; legal range 2..15.
REQ-002 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port scan_tick  input  1  one-clk strobe that advances scanning and debouncing.
REQ-005 SHALL have port cols  input  4  keypad column sense, active-high, asynchronous to clk.
REQ-006 SHALL have port clear  input  1  synchronous buffer clear, one-clk pulse.
REQ-007 SHALL have port rows  output  4  one-hot row drive, active-high.
REQ-008 SHALL have port key_valid  output  1  one-clk pulse per accepted key.
REQ-009 SHALL have port key_code  output  4  hex value of the last accepted key.
REQ-010 SHALL have port data  output  24  six-digit hex entry buffer; newest digit in [3:0].
REQ-011 SHALL have port enables  output  6  per-digit valid mask; bit i covers data[4i+3:4i].

Function
REQ-012 SHALL pass cols through a 2-flop synchronizer (cols_s); all decisions use cols_s only.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, HELD; every transition and counter update SHALL occur only on clk edges where scan_tick=1.
REQ-014 SHALL drive rows = one-hot(row_idx) in every state; row_idx SHALL hold fixed outside SCAN.
REQ-015 SCAN: cols_s exactly one-hot -> latch col_idx, clear cnt, go DEBOUNCE; otherwise row_idx <= row_idx+1 mod 4 (3 -> 0).
REQ-016 SCAN: cols_s with two or more bits set SHALL be treated as no key.
REQ-017 DEBOUNCE: cols_s equal to the latched column -> cnt+1; when DEBOUNCE_TICKS consecutive matches including the entry sample are reached, accept the key and go HELD.
REQ-018 DEBOUNCE: any mismatch -> SCAN with row_idx advanced by 1 and no key emitted.
REQ-019 Accept: key_code = {row_idx[1:0], col_idx[1:0]}, so row0/col0 = 0x0 and row3/col3 = 0xF.
REQ-020 On acceptance, key_valid SHALL be 1 for exactly the clk cycle after the accepting edge; key_code, data and enables SHALL update on that same edge.
REQ-021 Acceptance update: data <= {data[19:0], key_code}; enables <= {enables[4:0], 1}.
REQ-022 From the seventh key on, the oldest digit SHALL be discarded and enables SHALL stay at 6'b111111.
REQ-023 HELD: cols_s == 0 -> cnt+1, otherwise cnt <= 0; after DEBOUNCE_TICKS consecutive zero samples -> SCAN with row_idx+1.
REQ-024 A held key SHALL produce exactly one key_valid regardless of hold duration.
REQ-025 clear=1 SHALL set data=0 and enables=0 on the next edge; the FSM is unaffected.
REQ-026 clear coincident with acceptance: clear wins for data/enables; key_valid still pulses and key_code still updates.
REQ-027 scan_tick coincident with clear SHALL be processed normally by the FSM.

Reset
REQ-028 SHALL initialize on rst=1, regardless of clk or scan_tick: state=SCAN, row_idx=0, rows=4'b0001, cnt=0, col_idx=0, synchronizer flops=0, key_valid=0, key_code=0, data=0, enables=0.
REQ-029 rst asserted mid-debounce or mid-hold SHALL abandon the key; no key_valid SHALL follow the release of reset.

Structure
REQ-030 Package keypad_pkg SHALL hold the FSM state enum and constants N_ROWS=4, N_COLS=4, N_DIGITS=6.
REQ-031 The synchronizer SHALL be a separate sub-module, sync_2ff (4 bits wide, async reset to 0).
REQ-032 data and enables SHALL connect directly to the display multiplexer inputs of the same names and widths.

Verification (DEBOUNCE_TICKS=4; cols changed at least 3 clk before any scan_tick)
REQ-033 Assert rst -> rows=0001, data=0x000000, enables=000000, key_valid=0.
REQ-034 Drive cols=0010 while rows=0100 for 4 ticks -> one key_valid, key_code=0x9, data=0x000009, enables=000001.
REQ-035 cols=0001 on row0 for 2 ticks, then 0 -> no key_valid; rows advances to 0010 on the next tick.
REQ-036 Enter keys 1,2,3,4,5,6,7 (each pressed and released) -> data=0x234567, enables=111111, seven key_valid pulses.
REQ-037 Hold key 0x5 for 20 ticks, release for 4 ticks, press again -> exactly two key_valid pulses; cols=0011 -> none.
REQ-038 clear on the accept cycle of key 0xA with prior data=0x000012 -> key_valid=1, key_code=0xA, data=0, enables=0.
